// File: rtl/vx_pending_throttle.sv
// Outstanding-request throttle: caps in-flight requests at MAX_PENDING and drains on flush.
// Optional perf counters are enabled by defining VX_PENDING_THROTTLE_PERF_EN.
module vx_pending_throttle #(
  parameter int unsigned    MAX_PENDING = 4,
  parameter int unsigned    REQ_DATAW   = 32,
  parameter int unsigned    RSP_DATAW   = 32,
  localparam int unsigned   CNTW        = $clog2(MAX_PENDING + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,

  input  logic                 req_in_valid,
  output logic                 req_in_ready,
  input  logic [REQ_DATAW-1:0] req_in_data,

  output logic                 req_out_valid,
  input  logic                 req_out_ready,
  output logic [REQ_DATAW-1:0] req_out_data,

  input  logic                 rsp_in_valid,
  output logic                 rsp_in_ready,
  input  logic [RSP_DATAW-1:0] rsp_in_data,

  output logic                 rsp_out_valid,
  input  logic                 rsp_out_ready,
  output logic [RSP_DATAW-1:0] rsp_out_data,

  input  logic                 flush_req,
  output logic                 flush_done,

`ifdef VX_PENDING_THROTTLE_PERF_EN
  output logic [31:0]          perf_stall_cycles,
  output logic [CNTW-1:0]      perf_max_pending,
`endif

  output logic [CNTW-1:0]      pending,
  output logic                 empty,
  output logic                 full
);

  localparam logic [CNTW-1:0] MaxCnt = CNTW'(MAX_PENDING);

  typedef enum logic [1:0] {StRun, StDrain, StDone} state_e;

  state_e          state_q, state_d;
  logic [CNTW-1:0] pending_q, pending_d;
  logic            allow, incr, decr;

  // Gate only on registered state so no response-to-request combinational path exists.
  assign allow         = (state_q == StRun) && (pending_q != MaxCnt);

  assign req_out_valid = req_in_valid && allow;
  assign req_in_ready  = req_out_ready && allow;
  assign req_out_data  = req_in_data;

  assign rsp_out_valid = rsp_in_valid;
  assign rsp_in_ready  = rsp_out_ready;
  assign rsp_out_data  = rsp_in_data;

  assign incr = req_out_valid && req_out_ready;
  assign decr = rsp_out_valid && rsp_out_ready;

  always_comb begin
    pending_d = pending_q;
    if (incr && !decr) begin
      pending_d = pending_q + 1'b1;
    end else if (decr && !incr && (pending_q != '0)) begin
      pending_d = pending_q - 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (flush_req) state_d = StDrain;
      StDrain: if (pending_d == '0) state_d = StDone;
      StDone:  state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StRun;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  assign pending    = pending_q;
  assign empty      = (pending_q == '0);
  assign full       = (pending_q == MaxCnt);
  assign flush_done = (state_q == StDone);

`ifdef VX_PENDING_THROTTLE_PERF_EN
  logic [31:0]     stall_q;
  logic [CNTW-1:0] max_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
      max_q   <= '0;
    end else begin
      if (req_in_valid && !allow) stall_q <= stall_q + 32'd1;
      if (pending_d > max_q) max_q <= pending_d;
    end
  end

  assign perf_stall_cycles = stall_q;
  assign perf_max_pending  = max_q;
`endif

`ifndef SYNTHESIS
  // A response with nothing outstanding is dropped; flag it in simulation.
  always @(posedge clk) begin
    if (reset_n) begin
      assert (!(decr && !incr && (pending_q == '0)))
        else $warning("vx_pending_throttle: response with no outstanding request, count held at 0");
    end
  end
`endif

endmodule

// File: tb/tb_vx_pending_throttle.sv
// Directed self-checking bench for vx_pending_throttle (MAX_PENDING=4).
// Perf counter checks are compiled in when VX_PENDING_THROTTLE_PERF_EN is defined.
module tb_vx_pending_throttle;

  localparam int unsigned MAX_PENDING = 4;
  localparam int unsigned CNTW = $clog2(MAX_PENDING + 1);

  logic              clk = 1'b0;
  logic              reset_n;
  logic              req_in_valid, req_in_ready;
  logic [31:0]       req_in_data;
  logic              req_out_valid, req_out_ready;
  logic [31:0]       req_out_data;
  logic              rsp_in_valid, rsp_in_ready;
  logic [31:0]       rsp_in_data;
  logic              rsp_out_valid, rsp_out_ready;
  logic [31:0]       rsp_out_data;
  logic              flush_req, flush_done;
  logic [CNTW-1:0]   pending;
  logic              empty, full;
`ifdef VX_PENDING_THROTTLE_PERF_EN
  logic [31:0]       perf_stall_cycles;
  logic [CNTW-1:0]   perf_max_pending;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  vx_pending_throttle #(
    .MAX_PENDING (MAX_PENDING),
    .REQ_DATAW   (32),
    .RSP_DATAW   (32)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .req_in_valid      (req_in_valid),
    .req_in_ready      (req_in_ready),
    .req_in_data       (req_in_data),
    .req_out_valid     (req_out_valid),
    .req_out_ready     (req_out_ready),
    .req_out_data      (req_out_data),
    .rsp_in_valid      (rsp_in_valid),
    .rsp_in_ready      (rsp_in_ready),
    .rsp_in_data       (rsp_in_data),
    .rsp_out_valid     (rsp_out_valid),
    .rsp_out_ready     (rsp_out_ready),
    .rsp_out_data      (rsp_out_data),
    .flush_req         (flush_req),
    .flush_done        (flush_done),
`ifdef VX_PENDING_THROTTLE_PERF_EN
    .perf_stall_cycles (perf_stall_cycles),
    .perf_max_pending  (perf_max_pending),
`endif
    .pending           (pending),
    .empty             (empty),
    .full              (full)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n       = 1'b0;
    req_in_valid  = 1'b0;
    req_in_data   = '0;
    req_out_ready = 1'b1;
    rsp_in_valid  = 1'b0;
    rsp_in_data   = '0;
    rsp_out_ready = 1'b1;
    flush_req     = 1'b0;

    // Reset state
    #2;
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_flush_done", 32'(flush_done), 32'd0);
    chk("rst_req_in_ready", 32'(req_in_ready), 32'd1);
    chk("rst_req_out_valid", 32'(req_out_valid), 32'd0);
    chk("rst_rsp_in_ready", 32'(rsp_in_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Six back-to-back requests, no responses: only four fire
    req_in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      req_in_data = 32'hA000_0000 + 32'(i);
      #1;
      chk("fill_ready", 32'(req_in_ready), (i < 4) ? 32'd1 : 32'd0);
      chk("fill_pending", 32'(pending), (i < 4) ? 32'(i) : 32'd4);
      chk("fill_data", req_out_data, 32'hA000_0000 + 32'(i));
      tick();
    end
    req_in_valid = 1'b0;
    chk("full_pending", 32'(pending), 32'd4);
    chk("full_full", 32'(full), 32'd1);
    chk("full_empty", 32'(empty), 32'd0);

    // One response at full; request stays blocked in that same cycle
    rsp_in_valid = 1'b1;
    rsp_in_data  = 32'h5A5A_0001;
    req_in_valid = 1'b1;
    #1;
    chk("rsp_at_full_req_ready", 32'(req_in_ready), 32'd0);
    chk("rsp_at_full_rsp_ready", 32'(rsp_in_ready), 32'd1);
    chk("rsp_at_full_rsp_valid", 32'(rsp_out_valid), 32'd1);
    chk("rsp_at_full_rsp_data", rsp_out_data, 32'h5A5A_0001);
    tick();
    rsp_in_valid = 1'b0;
    #1;
    chk("after_rsp_pending", 32'(pending), 32'd3);
    chk("after_rsp_full", 32'(full), 32'd0);
    chk("after_rsp_req_ready", 32'(req_in_ready), 32'd1);
    chk("after_rsp_req_valid", 32'(req_out_valid), 32'd1);
    tick();
    req_in_valid = 1'b0;
    chk("refill_pending", 32'(pending), 32'd4);

    rsp_in_valid = 1'b1;
    tick();
    tick();
    rsp_in_valid = 1'b0;
    chk("two_rsp_pending", 32'(pending), 32'd2);

    // Simultaneous request and response fire
    req_in_valid = 1'b1;
    rsp_in_valid = 1'b1;
    tick();
    req_in_valid = 1'b0;
    rsp_in_valid = 1'b0;
    chk("both_pending", 32'(pending), 32'd2);
    chk("both_empty", 32'(empty), 32'd0);
    chk("both_full", 32'(full), 32'd0);

    req_in_valid = 1'b1;
    tick();
    req_in_valid = 1'b0;
    chk("pre_flush_pending", 32'(pending), 32'd3);

    // Flush pulse at pending=3, drained by three consecutive responses
    flush_req = 1'b1;
    tick();
    flush_req    = 1'b0;
    req_in_valid = 1'b1;
    rsp_in_valid = 1'b1;
    for (int j = 0; j < 3; j++) begin
      #1;
      chk("drain_req_ready", 32'(req_in_ready), 32'd0);
      chk("drain_req_valid", 32'(req_out_valid), 32'd0);
      chk("drain_flush_done", 32'(flush_done), 32'd0);
      chk("drain_pending", 32'(pending), 32'd3 - 32'(j));
      tick();
    end
    rsp_in_valid = 1'b0;
    #1;
    chk("done_flush_done", 32'(flush_done), 32'd1);
    chk("done_pending", 32'(pending), 32'd0);
    chk("done_empty", 32'(empty), 32'd1);
    chk("done_req_ready", 32'(req_in_ready), 32'd0);
    tick();
    chk("post_done_flush_done", 32'(flush_done), 32'd0);
    chk("post_done_req_ready", 32'(req_in_ready), 32'd1);
    tick();
    req_in_valid = 1'b0;
    chk("post_done_pending", 32'(pending), 32'd1);

    rsp_in_valid = 1'b1;
    tick();
    rsp_in_valid = 1'b0;
    chk("emptied_pending", 32'(pending), 32'd0);

    // Flush with nothing outstanding: RUN -> DRAIN -> DONE -> RUN
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    chk("zflush_drain_done", 32'(flush_done), 32'd0);
    tick();
    chk("zflush_done", 32'(flush_done), 32'd1);
    tick();
    chk("zflush_after", 32'(flush_done), 32'd0);

    // Underflow: response with nothing outstanding holds at 0
    rsp_in_valid = 1'b1;
    #1;
    chk("uflow_rsp_ready", 32'(rsp_in_ready), 32'd1);
    tick();
    rsp_in_valid = 1'b0;
    chk("uflow_pending", 32'(pending), 32'd0);
    chk("uflow_empty", 32'(empty), 32'd1);

    // Asynchronous reset in the middle of a drain at pending=2
    req_in_valid = 1'b1;
    tick();
    tick();
    req_in_valid = 1'b0;
    chk("mid_pending", 32'(pending), 32'd2);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    chk("mid_drain_ready", 32'(req_in_ready), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_pending", 32'(pending), 32'd0);
    chk("mid_rst_empty", 32'(empty), 32'd1);
    chk("mid_rst_full", 32'(full), 32'd0);
    chk("mid_rst_flush_done", 32'(flush_done), 32'd0);
    chk("mid_rst_run", 32'(req_in_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

`ifdef VX_PENDING_THROTTLE_PERF_EN
    // Fill, then hold a request at full for five cycles
    req_in_valid = 1'b1;
    repeat (4) tick();
    chk("perf_full_pending", 32'(pending), 32'd4);
    chk("perf_stall_before", perf_stall_cycles, 32'd0);
    repeat (5) tick();
    req_in_valid = 1'b0;
    chk("perf_stall", perf_stall_cycles, 32'd5);
    chk("perf_max", 32'(perf_max_pending), 32'd4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vx_pending_throttle.md
# vx_pending_throttle

Request/response throttle between a requester (e.g. LSU or cache-miss path) and a memory-side port. It caps outstanding requests at MAX_PENDING: request fires count up, response fires count down. It blocks new requests when the cap is reached or a flush is draining. It sits directly upstream of the pending-size counter and exports the same count/empty/full view, plus a drain handshake.

## Interface
- MAX_PENDING, 4: maximum outstanding requests (>=1)
- REQ_DATAW, 32: request payload width
- RSP_DATAW, 32: response payload width
- CNTW, $clog2(MAX_PENDING+1): count width (derived, do not override)

- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  reset, asynchronous assert, active-low
- req_in_valid / req_in_ready  in / out  1  upstream request handshake
- req_in_data  in  REQ_DATAW  request payload
- req_out_valid / req_out_ready  out / in  1  downstream request handshake
- req_out_data  out  REQ_DATAW  = req_in_data
- rsp_in_valid / rsp_in_ready  in / out  1  downstream response handshake
- rsp_in_data  in  RSP_DATAW  response payload
- rsp_out_valid / rsp_out_ready  out / in  1  upstream response handshake
- rsp_out_data  out  RSP_DATAW  = rsp_in_data
- flush_req  in  1  level; request drain of all outstanding traffic
- flush_done  out  1  one-cycle pulse when drain completes
- pending  out  CNTW  registered outstanding count
- empty / full  out  1  pending==0 / pending==MAX_PENDING

## Operation
- allow = (state==RUN) && (pending != MAX_PENDING).
- req_out_valid = req_in_valid && allow; req_in_ready = req_out_ready && allow. No dependence on the same-cycle response, so there is no rsp->req combinational path.
- rsp_out_valid = rsp_in_valid; rsp_in_ready = rsp_out_ready. Responses are never blocked.
- incr = req_out_valid && req_out_ready; decr = rsp_out_valid && rsp_out_ready.
- Next pending = pending + incr - decr, in CNTW bits. incr and decr together leave the count unchanged.
- Underflow (decr while pending==0, no incr): pending holds at 0. A simulation assertion fires.
- Overflow cannot occur because allow is low at full.
- FSM:
  - RUN: flush_req=1 -> DRAIN.
  - DRAIN: allow=0. When next pending==0 -> DONE.
  - DONE: flush_done=1 for this cycle only, then -> RUN. If flush_req is still high in DONE, the FSM returns to RUN, then re-enters DRAIN on the next cycle. The requester must deassert flush_req on seeing flush_done.
- flush_req in RUN with pending==0: RUN -> DRAIN -> DONE. flush_done is asserted 2 cycles after flush_req is sampled.

## Timing
- Request and response paths: zero latency, purely combinational passthrough.
- pending, empty, full: registered, updated the cycle after the fire. empty and full are decoded from registered pending.
- flush_done: registered, asserted exactly one cycle, while in DONE.
- Reset (reset_n=0, any cycle, including mid-drain): state=RUN, pending=0, empty=1, full=0, flush_done=0. In-flight responses are discarded from the count. Reset release is synchronized by the instantiating logic.
- Reset values of combinational outputs follow their equations with state=RUN and pending=0.

## Configuration
- VX_PENDING_THROTTLE_PERF_EN defined:
  - Adds output perf_stall_cycles, 32 bits, reset 0.
  - Increments each cycle req_in_valid && !allow; wraps at 2^32.
  - Adds output perf_max_pending, CNTW bits, reset 0, the high-water mark of pending.
- Undefined: neither port exists; no counters are synthesized. The functional behaviour is otherwise identical.

## Test plan
- MAX_PENDING=4, req_out_ready=1, issue 6 back-to-back requests, no responses -> exactly 4 fire; pending=4, full=1; req_in_ready=0 from the cycle after the 4th fire.
- At pending=4, give one response (rsp_out_ready=1) -> pending=3 next cycle, full=0. The next request fires one cycle after the response, never in the same cycle.
- At pending=2, request fire and response fire in the same cycle -> pending stays 2, empty=0, full=0.
- At pending=3, pulse flush_req -> req_in_ready=0 through the drain. Return 3 responses on consecutive cycles -> flush_done high exactly one cycle after pending reaches 0 (DONE), then requests are accepted again.
- With pending=0, response with rsp_out_ready=1 -> pending stays 0 and the assertion is reported. Separately, assert reset_n=0 mid-drain at pending=2 -> pending=0, empty=1, flush_done=0, state RUN.
- With PERF_EN: hold req_in_valid=1 at full for 5 cycles -> perf_stall_cycles=5, perf_max_pending=4.
